// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the front-panel controller.
//   state_t : up/down repeat FSM states
//   dir_t   : direction of the button that started the current press
//   BTN_*   : bit positions of the five buttons inside the button vectors
//   cnt_w() : counter width for a count of n values (never narrower than 1)
package counter_ctrl_pkg;

    localparam int DIG_W = 4;

    localparam int NUM_BTNS   = 5;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTRE = 4;

    typedef enum logic [1:0] {IDLE, FIRST, HOLD, REPEAT} state_t;
    typedef enum logic {UP, DN} dir_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw pushbutton.
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : asynchronous button pin
//   level      : debounced button level
//   rise, fall : one-cycle pulses, registered together with the level change
// A level change is accepted once the synchronized input has disagreed with
// the debounced level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                rise  <= ~level;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: front-panel controller driving hex_counter.
//   clk, reset          : system clock, asynchronous active-high reset
//                         (deassertion is expected to be synchronous upstream)
//   btn_up/down/left/right/centre : raw asynchronous pushbuttons
//   add, sub            : one-cycle increment/decrement pulses, hold-to-repeat
//   dig_incr            : selected digit index, 0..NUM_DIGITS-1
//   counter_clear       : one-cycle clear pulse after a long centre press
//   repeating           : high while auto-repeat is running
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS      = 9,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CLEAR_HOLD      = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_centre,
    output logic             add,
    output logic             sub,
    output logic [DIG_W-1:0] dig_incr,
    output logic             counter_clear,
    output logic             repeating
);

    localparam int TW  = (cnt_w(REPEAT_DELAY) > cnt_w(REPEAT_PERIOD)) ?
                         cnt_w(REPEAT_DELAY) : cnt_w(REPEAT_PERIOD);
    localparam int CLW = cnt_w(CLEAR_HOLD);

    logic [NUM_BTNS-1:0] raw;
    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] fall;

    assign raw = {btn_centre, btn_right, btn_left, btn_down, btn_up};

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[b]),
            .level (level[b]),
            .rise  (rise[b]),
            .fall  (fall[b])
        );
    end

    // Edges and levels the controller has no use for.
    logic unused_edges;
    assign unused_edges = ^{level[BTN_LEFT], level[BTN_RIGHT], rise[BTN_CENTRE],
                            fall[BTN_LEFT], fall[BTN_RIGHT], fall[BTN_CENTRE]};

    // ---------------- long-press clear ----------------
    logic [CLW-1:0] clr_cnt;
    logic           clr_done;
    logic           clear_fire;

    // The counter parks at its top value; clr_done blocks a second pulse
    // until centre is released.
    assign clear_fire = level[BTN_CENTRE] && !clr_done &&
                        (clr_cnt == CLW'(CLEAR_HOLD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt       <= '0;
            clr_done      <= 1'b0;
            counter_clear <= 1'b0;
        end else begin
            counter_clear <= clear_fire;
            if (!level[BTN_CENTRE]) begin
                clr_cnt  <= '0;
                clr_done <= 1'b0;
            end else if (clr_cnt == CLW'(CLEAR_HOLD - 1)) begin
                clr_done <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // ---------------- up/down repeat FSM ----------------
    state_t        state;
    dir_t          dir;
    logic [TW-1:0] timer;
    logic          cancel;

    assign cancel = (dir == UP) ? (fall[BTN_UP]   | rise[BTN_DOWN])
                                : (fall[BTN_DOWN] | rise[BTN_UP]);

    // The timer is loaded on the same edge that raises a pulse, so both
    // intervals are measured pulse-to-pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= UP;
            timer     <= '0;
            add       <= 1'b0;
            sub       <= 1'b0;
            repeating <= 1'b0;
        end else begin
            add <= 1'b0;
            sub <= 1'b0;
            if (clear_fire) begin
                state     <= IDLE;
                repeating <= 1'b0;
            end else if (state == IDLE) begin
                if (rise[BTN_UP] && !level[BTN_DOWN]) begin
                    state <= FIRST;
                    dir   <= UP;
                    add   <= 1'b1;
                    timer <= TW'(REPEAT_DELAY - 1);
                end else if (rise[BTN_DOWN] && !level[BTN_UP]) begin
                    state <= FIRST;
                    dir   <= DN;
                    sub   <= 1'b1;
                    timer <= TW'(REPEAT_DELAY - 1);
                end
            end else if (cancel) begin
                state     <= IDLE;
                repeating <= 1'b0;
            end else if (timer == '0) begin
                state     <= REPEAT;
                repeating <= 1'b1;
                add       <= (dir == UP);
                sub       <= (dir == DN);
                timer     <= TW'(REPEAT_PERIOD - 1);
            end else begin
                timer <= timer - 1'b1;
                if (state == FIRST) begin
                    state <= HOLD;
                end
            end
        end
    end

    // ---------------- digit select ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_incr <= '0;
        end else if (!clear_fire) begin
            if (rise[BTN_LEFT] && !rise[BTN_RIGHT]) begin
                dig_incr <= (dig_incr == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_incr + 1'b1;
            end else if (rise[BTN_RIGHT] && !rise[BTN_LEFT]) begin
                dig_incr <= (dig_incr == '0) ? DIG_W'(NUM_DIGITS - 1) : dig_incr - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: self-checking bench for counter_ctrl with short timing
// parameters. A timestamp-based reference model tracks expected outputs.
module tb_counter_ctrl;

    localparam int NUM_DIGITS      = 9;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 10;
    localparam int REPEAT_PERIOD   = 3;
    localparam int CLEAR_HOLD      = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic       btn_right = 1'b0, btn_centre = 1'b0;
    logic       add, sub, counter_clear, repeating;
    logic [3:0] dig_incr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_ctrl #(
        .NUM_DIGITS      (NUM_DIGITS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CLEAR_HOLD      (CLEAR_HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_centre    (btn_centre),
        .add           (add),
        .sub           (sub),
        .dig_incr      (dig_incr),
        .counter_clear (counter_clear),
        .repeating     (repeating)
    );

    // ---------------- reference model ----------------
    // Buttons: 0 up, 1 down, 2 left, 3 right, 4 centre.
    int       ecount = 0;   // rising edges since the last reset release
    bit [4:0] m_h1, m_h2;   // raw samples one and two edges ago
    bit [4:0] m_lvl, m_rs, m_fs;
    int       m_run [5];
    int       m_held;       // edges the debounced centre has been high
    bit       m_active, m_up;
    int       m_next;       // edge number of the next scheduled pulse
    int       m_dig;
    bit       m_add, m_sub, m_clear, m_rep;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_lvl = '0; m_rs = '0; m_fs = '0;
        for (int b = 0; b < 5; b++) m_run[b] = 0;
        m_held = 0; m_active = 0; m_up = 0; m_next = 0; m_dig = 0;
        m_add = 0; m_sub = 0; m_clear = 0; m_rep = 0;
    endtask

    task automatic model_step();
        bit fire;
        ecount++;
        m_add = 0; m_sub = 0; fire = 0;
        if (m_lvl[4]) begin
            m_held++;
            fire = (m_held == CLEAR_HOLD);
        end else begin
            m_held = 0;
        end
        m_clear = fire;
        if (fire) begin
            m_active = 0; m_rep = 0;
        end else if (m_active) begin
            if (m_up ? (m_fs[0] || m_rs[1]) : (m_fs[1] || m_rs[0])) begin
                m_active = 0; m_rep = 0;
            end else if (ecount == m_next) begin
                m_add = m_up; m_sub = !m_up; m_rep = 1;
                m_next = ecount + REPEAT_PERIOD;
            end
        end else if (m_rs[0] && !m_lvl[1]) begin
            m_active = 1; m_up = 1; m_add = 1; m_next = ecount + REPEAT_DELAY;
        end else if (m_rs[1] && !m_lvl[0]) begin
            m_active = 1; m_up = 0; m_sub = 1; m_next = ecount + REPEAT_DELAY;
        end
        if (!fire) begin
            if (m_rs[2] && !m_rs[3])      m_dig = (m_dig + 1) % NUM_DIGITS;
            else if (m_rs[3] && !m_rs[2]) m_dig = (m_dig + NUM_DIGITS - 1) % NUM_DIGITS;
        end
        // A level flips once the twice-registered raw value has disagreed
        // with it on DEBOUNCE_CYCLES edges in a row.
        for (int b = 0; b < 5; b++) begin
            m_rs[b] = 0; m_fs[b] = 0;
            if (m_h2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEBOUNCE_CYCLES) begin
                    m_lvl[b] = !m_lvl[b];
                    m_rs[b] = m_lvl[b];
                    m_fs[b] = !m_lvl[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_h2 = m_h1;
        m_h1 = {btn_centre, btn_right, btn_left, btn_down, btn_up};
    endtask

    // One clock: model follows the edge, then wait for the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
    endtask

    function automatic logic [7:0] dut_vec();
        return {add, sub, counter_clear, repeating, dig_incr};
    endfunction

    function automatic logic [7:0] model_vec();
        return {m_add, m_sub, m_clear, m_rep, 4'(m_dig)};
    endfunction

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_up = v;
            1: btn_down = v;
            2: btn_left = v;
            3: btn_right = v;
            default: btn_centre = v;
        endcase
    endtask

    task automatic press(input int b, input int on_cycles, input int off_cycles);
        set_btn(b, 1'b1);
        repeat (on_cycles) tick();
        set_btn(b, 1'b0);
        repeat (off_cycles) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got %b want 00000000", dut_vec());
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL post_reset edge %0d got %b want %b", ecount, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_hold_repeat();
        int e0;
        int pulses[$];
        int exp_p[5] = '{7, 17, 20, 23, 26};
        bit sub_seen = 0;
        btn_up = 1'b1;
        e0 = ecount;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) btn_up = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL hold_model edge %0d got %b want %b", ecount - e0, dut_vec(), model_vec());
            end
            if (add) pulses.push_back(ecount - e0);
            if (sub) sub_seen = 1;
            if (ecount - e0 == 16 || ecount - e0 == 17 || ecount - e0 == 27) begin
                checks++;
                if (repeating !== (ecount - e0 == 17)) begin
                    errors++;
                    $display("FAIL hold_repeating edge %0d got %b", ecount - e0, repeating);
                end
            end
        end
        checks++;
        if (sub_seen) begin
            errors++;
            $display("FAIL hold_sub got 1 want 0");
        end
        checks++;
        if (pulses.size() != 5) begin
            errors++;
            $display("FAIL hold_pulse_count got %0d want 5", pulses.size());
        end else begin
            foreach (exp_p[k]) begin
                checks++;
                if (pulses[k] != exp_p[k]) begin
                    errors++;
                    $display("FAIL hold_pulse_%0d got %0d want %0d", k, pulses[k], exp_p[k]);
                end
            end
        end
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int e0;
        int bounce_adds = 0;
        int pulses[$];
        for (int i = 0; i < 32; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bounce_model edge %0d got %b want %b", ecount, dut_vec(), model_vec());
            end
            if (add) bounce_adds++;
        end
        checks++;
        if (bounce_adds != 0) begin
            errors++;
            $display("FAIL bounce_no_add got %0d pulses want 0", bounce_adds);
        end
        btn_up = 1'b1;
        e0 = ecount;
        for (int i = 0; i < 25; i++) begin
            if (i == 8) btn_up = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bounce_model edge %0d got %b want %b", ecount, dut_vec(), model_vec());
            end
            if (add) pulses.push_back(ecount - e0);
        end
        checks++;
        if (pulses.size() != 1 || pulses[0] != 7) begin
            errors++;
            $display("FAIL bounce_stable_pulse got count %0d first %0d want 1 at 7",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        repeat (5) tick();
    endtask

    task automatic test_digit_select();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            press(2, 6, 8);
            checks++;
            if (dig_incr !== 4'(k % NUM_DIGITS)) begin
                errors++;
                $display("FAIL digit_left_%0d got %0d want %0d", k, dig_incr, k % NUM_DIGITS);
            end
        end
        press(3, 6, 8);
        checks++;
        if (dig_incr !== 4'(NUM_DIGITS - 1)) begin
            errors++;
            $display("FAIL digit_right_wrap got %0d want %0d", dig_incr, NUM_DIGITS - 1);
        end
    endtask

    task automatic test_up_down_conflict();
        int e0;
        int pulses = 0;
        int first_add = -1;
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 47; i++) begin
            if (i == 20) btn_down = 1'b0;
            if (i == 35) btn_up = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL conflict_model edge %0d got %b want %b", ecount, dut_vec(), model_vec());
            end
            if (add || sub) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL conflict_no_pulse got %0d pulses want 0", pulses);
        end
        btn_up = 1'b1;
        e0 = ecount;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) btn_up = 1'b0;
            tick();
            checks++;
            if (add && sub) begin
                errors++;
                $display("FAIL conflict_add_and_sub edge %0d", ecount - e0);
            end
            if (add && first_add < 0) first_add = ecount - e0;
        end
        checks++;
        if (first_add != 7) begin
            errors++;
            $display("FAIL conflict_repress got %0d want 7", first_add);
        end
        repeat (5) tick();
    endtask

    task automatic test_clear();
        int e0;
        int clears[$];
        int short_clears = 0;
        btn_centre = 1'b1;
        e0 = ecount;
        for (int i = 0; i < 35; i++) begin
            if (i == 20) btn_centre = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL clear_model edge %0d got %b want %b", ecount, dut_vec(), model_vec());
            end
            if (counter_clear) clears.push_back(ecount - e0);
        end
        checks++;
        if (clears.size() != 1 || clears[0] != 2 + DEBOUNCE_CYCLES + CLEAR_HOLD) begin
            errors++;
            $display("FAIL clear_long got count %0d first %0d want 1 at %0d", clears.size(),
                     (clears.size() > 0) ? clears[0] : -1, 2 + DEBOUNCE_CYCLES + CLEAR_HOLD);
        end
        btn_centre = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) btn_centre = 1'b0;
            tick();
            if (counter_clear) short_clears++;
        end
        checks++;
        if (short_clears != 0) begin
            errors++;
            $display("FAIL clear_short got %0d pulses want 0", short_clears);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int e0;
        int first_add = -1;
        bit seen_rep = 0;
        do_reset();
        for (int k = 0; k < 5; k++) press(2, 6, 8);
        checks++;
        if (dig_incr !== 4'd5) begin
            errors++;
            $display("FAIL midreset_digit got %0d want 5", dig_incr);
        end
        btn_up = 1'b1;
        for (int i = 0; i < 40 && !seen_rep; i++) begin
            tick();
            seen_rep = repeating;
        end
        checks++;
        if (!seen_rep) begin
            errors++;
            $display("FAIL midreset_reach_repeat got 0 want 1 within 40 cycles");
        end
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async got %b want 00000000", dut_vec());
        end
        tick();
        tick();
        reset = 1'b0;
        e0 = ecount;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) btn_up = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL midreset_model edge %0d got %b want %b", ecount - e0, dut_vec(), model_vec());
            end
            if (add && first_add < 0) first_add = ecount - e0;
        end
        checks++;
        if (first_add != 7) begin
            errors++;
            $display("FAIL midreset_first_add got %0d want 7", first_add);
        end
        repeat (10) tick();
    endtask

    task automatic test_random();
        int len;
        int pulses = 0;
        logic [4:0] pat;
        for (int seg = 0; seg < 150; seg++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 12);
            pat = 5'($urandom);
            if ($urandom_range(0, 3) != 0) pat[4] = 1'b0;
            {btn_centre, btn_right, btn_left, btn_down, btn_up} = pat;
            for (int i = 0; i < len; i++) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random_model edge %0d got %b want %b", ecount, dut_vec(), model_vec());
                end
                if (add || sub) pulses++;
            end
        end
        checks++;
        if (pulses == 0) begin
            errors++;
            $display("FAIL random_activity got 0 pulses want >0");
        end
        {btn_centre, btn_right, btn_left, btn_down, btn_up} = 5'b0;
        repeat (15) tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_repeat();
        test_bounce();
        test_digit_select();
        test_up_down_conflict();
        test_clear();
        test_reset_mid_repeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Front-panel controller that sequences hex_counter from five raw pushbuttons: up, down, left, right, centre.
- Produces single-cycle add/sub pulses with hold-to-repeat, a digit-select index for dig_incr, and a long-press clear.
- Sits between the board button pins and hex_counter; its outputs drive add, sub, dig_incr and reset of hex_counter directly.

Parameters:
- NUM_DIGITS, 9, number of selectable digits; dig_incr ranges 0..NUM_DIGITS-1.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized cycles required to accept a level change.
- REPEAT_DELAY, 25000000, hold cycles after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses.
- CLEAR_HOLD, 100000000, centre-button hold cycles before the clear pulse fires.

Ports:
- clk input 1 system clock.
- reset input 1 asynchronous, active-high.
- btn_up input 1 raw, asynchronous, active-high.
- btn_down input 1 raw, asynchronous, active-high.
- btn_left input 1 raw, asynchronous, active-high.
- btn_right input 1 raw, asynchronous, active-high.
- btn_centre input 1 raw, asynchronous, active-high.
- add output 1 one-cycle increment pulse to hex_counter.
- sub output 1 one-cycle decrement pulse to hex_counter.
- dig_incr output 4 selected digit index.
- counter_clear output 1 one-cycle clear pulse, ORed into hex_counter reset by the parent.
- repeating output 1 high while the up/down FSM is in REPEAT.

Behaviour:
- Reset (async assert, sync release): add=0, sub=0, dig_incr=0, counter_clear=0, repeating=0, FSM=IDLE, all synchronizers, debounce counters and debounced levels cleared to 0.

Input conditioning:
- Each button passes through a 2-flop synchronizer, then a debounce counter.
- The counter resets whenever the synchronized level equals the current debounced level; otherwise it increments.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- Event pulses are registered rising/falling edges of the debounced levels.
- Latency from a stable raw edge to the debounced edge pulse: 2 + DEBOUNCE_CYCLES cycles. Outputs appear one cycle later.

Up/down FSM (states IDLE, FIRST, HOLD, REPEAT):
- IDLE: on an up rise with down low -> FIRST, dir=UP. Symmetric for down with dir=DN.
- IDLE: up and down both debounced high -> stay IDLE, no pulse.
- FIRST: emit one pulse (add if UP, sub if DN), load the timer with REPEAT_DELAY-1 -> HOLD.
- HOLD: timer decrements; at 0 -> REPEAT with a pulse and the timer loaded with REPEAT_PERIOD-1.
- REPEAT: pulse each time the timer hits 0, then reload.
- Any state: the active button's debounced level falling, or the opposite button rising -> IDLE the next cycle, with no pulse that cycle.
- add and sub are never high together. Each is high for exactly one cycle per pulse.

Digit select:
- Left rise: dig_incr+1, wrapping NUM_DIGITS-1 -> 0.
- Right rise: dig_incr-1, wrapping 0 -> NUM_DIGITS-1.
- Left and right rising in the same cycle: no change.
- Digit changes do not affect the up/down FSM. A repeat in progress continues on the new digit from the next pulse onward.

Clear:
- A hold counter runs while debounced centre is high.
- When it reaches CLEAR_HOLD-1: counter_clear=1 for one cycle, then the counter saturates. No further clear until centre is released and pressed again.
- Centre release before CLEAR_HOLD: no effect.
- counter_clear also forces the up/down FSM to IDLE and holds dig_incr unchanged.

Widths:
- Timers and counters are sized with $clog2 of their parameter. No overflow is possible because all counters either saturate or reload.

Decomposition:
- Package counter_ctrl_pkg: FSM state enum (IDLE, FIRST, HOLD, REPEAT), direction enum (UP, DN), DIG_W=4 localparam.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, raw, level, rise, fall) holds the synchronizer, debounce counter and edge detector.
- counter_ctrl instantiates btn_debounce five times.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CLEAR_HOLD=8, NUM_DIGITS=9):
1. btn_up high 20 cycles, glitch-free -> single add pulse 7 cycles after the raw edge. The next pulse arrives 10 cycles later, then one every 3 cycles while held. sub stays 0 throughout. repeating=1 from the second pulse until release.
2. btn_up toggled every 2 cycles for 30 cycles (bounce) -> no add pulse. A final stable high then gives exactly one pulse after 7 cycles.
3. Nine left presses from reset -> dig_incr steps 1..8 then 0. One right press from 0 -> dig_incr=8.
4. btn_up and btn_down raised in the same cycle and held -> add=0 and sub=0 for the full hold. Release down -> no pulse until up is released and pressed again.
5. btn_centre held 20 cycles -> exactly one counter_clear pulse at raw+2+4+8. A hold of 5 cycles gives no pulse.
6. Assert reset mid-REPEAT with dig_incr=5 -> all outputs 0 immediately (asynchronous). After release with up still held, the first add pulse arrives only after a full 7-cycle debounce.
